// File: rtl/tlu_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tlu_emulator                                                    |
// | Purpose  : EUDET-style TLU stand-in: issues a trigger, waits for BUSY,     |
// |            shifts the trigger number out LSB-first on TLU_CLOCK rises.     |
// | Option   : define TLU_EMULATOR_TIMEOUT_EN to abort stalled handshakes.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tlu_emulator #(
  parameter int TRIGGER_BITS = 15,
  parameter int TIMEOUT      = 1023
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    trigger_req,
  input  logic                    number_set,
  input  logic [TRIGGER_BITS-1:0] number_in,
  input  logic                    tlu_busy,
  input  logic                    tlu_clock,
  output logic                    tlu_trigger,
  output logic [TRIGGER_BITS-1:0] trigger_number,
  output logic                    ready,
  output logic [7:0]              veto_cnt,
  output logic [7:0]              timeout_cnt
);

  localparam int                       c_cnt_w    = $clog2(TRIGGER_BITS + 1);
  localparam logic [c_cnt_w-1:0]       c_last_bit = c_cnt_w'(TRIGGER_BITS - 1);
  localparam logic [c_cnt_w-1:0]       c_cnt_one  = c_cnt_w'(1);
  localparam logic [TRIGGER_BITS-1:0]  c_num_one  = TRIGGER_BITS'(1);

  if (TRIGGER_BITS < 1 || TRIGGER_BITS > 31 || TIMEOUT < 1) begin : g_bad_params
    $error("tlu_emulator: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT_BUSY    = 2'd1,
    S_SHIFT        = 2'd2,
    S_WAIT_RELEASE = 2'd3
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic                      r_busy_meta, r_busy_sync;
  logic                      r_clk_meta, r_clk_sync, r_clk_dly, r_clk_rise;
  logic                      r_trigger, w_trigger_nxt;
  logic [TRIGGER_BITS-1:0]   r_number, w_number_nxt;
  logic [TRIGGER_BITS-1:0]   r_shift, w_shift_nxt;
  logic [c_cnt_w-1:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]                r_veto_cnt, w_veto_cnt_nxt;
  logic                      w_timeout;

  // The registered rise pulse gives a fixed 4-cycle TLU_CLOCK-to-data latency.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_busy_meta <= 1'b0;
      r_busy_sync <= 1'b0;
      r_clk_meta  <= 1'b0;
      r_clk_sync  <= 1'b0;
      r_clk_dly   <= 1'b0;
      r_clk_rise  <= 1'b0;
    end else begin
      r_busy_meta <= tlu_busy;
      r_busy_sync <= r_busy_meta;
      r_clk_meta  <= tlu_clock;
      r_clk_sync  <= r_clk_meta;
      r_clk_dly   <= r_clk_sync;
      r_clk_rise  <= r_clk_sync & ~r_clk_dly;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= S_IDLE;
      r_trigger  <= 1'b0;
      r_number   <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_veto_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_trigger  <= w_trigger_nxt;
      r_number   <= w_number_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_veto_cnt <= w_veto_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_trigger_nxt  = r_trigger;
    w_number_nxt   = r_number;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_veto_cnt_nxt = r_veto_cnt;

    if (trigger_req && (r_state != S_IDLE) && (r_veto_cnt != 8'hFF)) begin
      w_veto_cnt_nxt = r_veto_cnt + 8'd1;
    end

    case (r_state)
      S_IDLE: begin
        // A request in the same cycle as a load wins; the load is dropped.
        if (trigger_req) begin
          w_state_nxt   = S_WAIT_BUSY;
          w_trigger_nxt = 1'b1;
          w_shift_nxt   = r_number;
          w_bit_cnt_nxt = '0;
        end else if (number_set) begin
          w_number_nxt  = number_in;
        end
      end
      S_WAIT_BUSY: begin
        if (r_busy_sync) begin
          w_state_nxt   = S_SHIFT;
          w_trigger_nxt = 1'b0;
        end
      end
      S_SHIFT: begin
        if (r_clk_rise) begin
          w_trigger_nxt = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = r_bit_cnt + c_cnt_one;
          if (r_bit_cnt == c_last_bit) begin
            w_state_nxt = S_WAIT_RELEASE;
          end
        end
      end
      S_WAIT_RELEASE: begin
        w_trigger_nxt = 1'b0;
        if (!r_busy_sync) begin
          w_state_nxt  = S_IDLE;
          w_number_nxt = r_number + c_num_one;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_timeout) begin
      w_state_nxt   = S_IDLE;
      w_trigger_nxt = 1'b0;
      w_number_nxt  = r_number + c_num_one;
    end
  end

`ifdef TLU_EMULATOR_TIMEOUT_EN
  localparam int                   c_timer_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT - 1);
  localparam logic [c_timer_w-1:0] c_timer_one  = c_timer_w'(1);

  logic [c_timer_w-1:0] r_timer;
  logic [7:0]           r_timeout_cnt;
  logic                 w_waiting;

  assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_RELEASE);
  assign w_timeout = w_waiting && (r_timer == c_timer_last);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_timer       <= '0;
      r_timeout_cnt <= '0;
    end else begin
      if (!w_waiting || (w_state_nxt != r_state)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + c_timer_one;
      end
      if (w_timeout && (r_timeout_cnt != 8'hFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 8'd1;
      end
    end
  end

  assign timeout_cnt = r_timeout_cnt;
`else
  assign w_timeout   = 1'b0;
  assign timeout_cnt = 8'd0;
`endif

  assign tlu_trigger    = r_trigger;
  assign trigger_number = r_number;
  assign ready          = (r_state == S_IDLE);
  assign veto_cnt       = r_veto_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tlu_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tlu_emulator                                                 |
// | Purpose  : Self-checking bench; plays the DUT side of the TLU handshake.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_tlu_emulator;

  localparam int TB_BITS = 15;

  logic               clk = 1'b0;
  logic               rst_b = 1'b0;
  logic               trigger_req = 1'b0;
  logic               number_set = 1'b0;
  logic [TB_BITS-1:0] number_in = '0;
  logic               tlu_busy = 1'b0;
  logic               tlu_clock = 1'b0;
  logic               tlu_trigger;
  logic [TB_BITS-1:0] trigger_number;
  logic               ready;
  logic [7:0]         veto_cnt;
  logic [7:0]         timeout_cnt;

  int                 checks = 0;
  int                 failures = 0;
  logic [TB_BITS-1:0] m_number = '0;
  logic [TB_BITS-1:0] exp_q[$];

  tlu_emulator #(
    .TRIGGER_BITS (TB_BITS),
    .TIMEOUT      (1023)
  ) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .trigger_req    (trigger_req),
    .number_set     (number_set),
    .number_in      (number_in),
    .tlu_busy       (tlu_busy),
    .tlu_clock      (tlu_clock),
    .tlu_trigger    (tlu_trigger),
    .trigger_number (trigger_number),
    .ready          (ready),
    .veto_cnt       (veto_cnt),
    .timeout_cnt    (timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_b       = 1'b0;
    trigger_req = 1'b0;
    number_set  = 1'b0;
    tlu_busy    = 1'b0;
    tlu_clock   = 1'b0;
    tick(2);
    rst_b = 1'b1;
    tick(1);
    m_number = '0;
    exp_q.delete();
  endtask

  // One full handshake as seen from the DUT side; the expected word is queued
  // when the request is driven and compared when the shifted word is complete.
  task automatic run_handshake(input int n_veto, input int abort_at,
                               input bit early_release, input bit extra_clk,
                               input bit collide);
    logic [TB_BITS-1:0] word;
    logic [TB_BITS-1:0] exp_word;
    int                 waited;
    bit                 aborted;
    word    = '0;
    aborted = 1'b0;
    exp_q.push_back(m_number);
    trigger_req = 1'b1;
    if (collide) begin
      number_set = 1'b1;
      number_in  = ~m_number;
    end
    tick(1);
    trigger_req = 1'b0;
    number_set  = 1'b0;
    checks++;
    if (tlu_trigger !== 1'b1 || ready !== 1'b0) begin
      failures++;
      $display("FAIL req_latency: tlu_trigger=%b ready=%b, required 1 0", tlu_trigger, ready);
    end
    tick(5);
    tlu_busy = 1'b1;
    tick(2);
    checks++;
    if (tlu_trigger !== 1'b1) begin
      failures++;
      $display("FAIL busy_early: tlu_trigger=%b, required 1", tlu_trigger);
    end
    tick(1);
    checks++;
    if (tlu_trigger !== 1'b0) begin
      failures++;
      $display("FAIL busy_ack: tlu_trigger=%b, required 0", tlu_trigger);
    end
    for (int i = 0; i < TB_BITS && !aborted; i++) begin
      if (i == abort_at) begin
        rst_b = 1'b0;
        #2;
        checks++;
        if (tlu_trigger !== 1'b0 || trigger_number !== '0 || ready !== 1'b1) begin
          failures++;
          $display("FAIL async_reset: trigger=%b number=%h ready=%b, required 0 0000 1",
                   tlu_trigger, trigger_number, ready);
        end
        #1;
        rst_b     = 1'b1;
        tlu_busy  = 1'b0;
        tlu_clock = 1'b0;
        m_number  = '0;
        exp_q.delete();
        aborted   = 1'b1;
      end else begin
        tlu_clock = 1'b1;
        tick(4);
        word[i] = tlu_trigger;
        if (early_release && i == 7) tlu_busy = 1'b0;
        tick(8);
        tlu_clock = 1'b0;
        if (i < n_veto) begin
          trigger_req = 1'b1;
          tick(1);
          trigger_req = 1'b0;
          tick(11);
        end else begin
          tick(12);
        end
      end
    end
    if (!aborted) begin
      checks++;
      if (tlu_trigger !== 1'b0) begin
        failures++;
        $display("FAIL release_low: tlu_trigger=%b, required 0", tlu_trigger);
      end
      if (extra_clk) begin
        tlu_clock = 1'b1;
        tick(6);
        checks++;
        if (tlu_trigger !== 1'b0 || ready !== 1'b0) begin
          failures++;
          $display("FAIL extra_clk: trigger=%b ready=%b, required 0 0", tlu_trigger, ready);
        end
        tlu_clock = 1'b0;
        tick(6);
      end
      tlu_busy = 1'b0;
      waited   = 0;
      while (ready !== 1'b1 && waited < 10) begin
        tick(1);
        waited++;
      end
      checks++;
      if (ready !== 1'b1) begin
        failures++;
        $display("FAIL ready_return: ready=%b after %0d cycles, required 1", ready, waited);
      end
      if (!early_release) begin
        checks++;
        if (waited != 3) begin
          failures++;
          $display("FAIL release_latency: %0d cycles, required 3", waited);
        end
      end
      m_number = m_number + 1'b1;
      checks++;
      if (trigger_number !== m_number) begin
        failures++;
        $display("FAIL number_incr: got %h, required %h", trigger_number, m_number);
      end
      exp_word = exp_q.pop_front();
      checks++;
      if (word !== exp_word) begin
        failures++;
        $display("FAIL word: got %h, required %h", word, exp_word);
      end
    end
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if (tlu_trigger !== 1'b0 || trigger_number !== '0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: trigger=%b number=%h ready=%b, required 0 0000 1",
               tlu_trigger, trigger_number, ready);
    end
    checks++;
    if (veto_cnt !== 8'd0 || timeout_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_counters: veto=%0d timeout=%0d, required 0 0", veto_cnt, timeout_cnt);
    end
  endtask

  task automatic test_basic_loop;
    run_handshake(0, -1, 1'b0, 1'b0, 1'b0);
    run_handshake(0, -1, 1'b0, 1'b0, 1'b0);
    run_handshake(0, -1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (trigger_number !== 15'd3) begin
      failures++;
      $display("FAIL basic_final_number: got %h, required 0003", trigger_number);
    end
  endtask

  task automatic test_early_release;
    run_handshake(0, -1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_load_wrap;
    number_in  = 15'h7FFF;
    number_set = 1'b1;
    tick(1);
    number_set = 1'b0;
    checks++;
    if (trigger_number !== 15'h7FFF) begin
      failures++;
      $display("FAIL load: got %h, required 7fff", trigger_number);
    end
    m_number = 15'h7FFF;
    run_handshake(0, -1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (trigger_number !== 15'h0000) begin
      failures++;
      $display("FAIL wrap: got %h, required 0000", trigger_number);
    end
  endtask

  task automatic test_collision;
    run_handshake(0, -1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_veto;
    apply_reset();
    run_handshake(4, -1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (veto_cnt !== 8'd4) begin
      failures++;
      $display("FAIL veto_count: got %0d, required 4", veto_cnt);
    end
  endtask

  task automatic test_reset_mid_shift;
    number_in  = 15'h5A5A;
    number_set = 1'b1;
    tick(1);
    number_set = 1'b0;
    m_number   = 15'h5A5A;
    run_handshake(0, 7, 1'b0, 1'b0, 1'b0);
    tick(2);
    run_handshake(0, -1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (trigger_number !== 15'd1) begin
      failures++;
      $display("FAIL post_reset_number: got %h, required 0001", trigger_number);
    end
  endtask

  task automatic test_veto_saturate;
    bit dropped;
    trigger_req = 1'b1;
    tick(1);
    trigger_req = 1'b0;
    for (int i = 0; i < 300; i++) begin
      trigger_req = 1'b1;
      tick(1);
      trigger_req = 1'b0;
      tick(1);
    end
    checks++;
    if (veto_cnt !== 8'd255) begin
      failures++;
      $display("FAIL veto_saturate: got %0d, required 255", veto_cnt);
    end
`ifndef TLU_EMULATOR_TIMEOUT_EN
    dropped = 1'b0;
    for (int i = 0; i < 5000 - 601; i++) begin
      tick(1);
      if (tlu_trigger !== 1'b1 || ready !== 1'b0) dropped = 1'b1;
    end
    checks++;
    if (dropped) begin
      failures++;
      $display("FAIL no_timeout_hold: trigger=%b ready=%b, required 1 0 throughout",
               tlu_trigger, ready);
    end
    checks++;
    if (timeout_cnt !== 8'd0) begin
      failures++;
      $display("FAIL no_timeout_cnt: got %0d, required 0", timeout_cnt);
    end
`endif
    apply_reset();
  endtask

`ifdef TLU_EMULATOR_TIMEOUT_EN
  task automatic test_timeout;
    int high_cycles;
    trigger_req = 1'b1;
    tick(1);
    trigger_req = 1'b0;
    high_cycles = 0;
    while (tlu_trigger === 1'b1 && high_cycles < 2000) begin
      tick(1);
      high_cycles++;
    end
    checks++;
    if (high_cycles < 1022 || high_cycles > 1024) begin
      failures++;
      $display("FAIL timeout_len: high %0d cycles, required about 1023", high_cycles);
    end
    checks++;
    if (timeout_cnt !== 8'd1 || trigger_number !== 15'd1 || ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_state: cnt=%0d number=%h ready=%b, required 1 0001 1",
               timeout_cnt, trigger_number, ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_loop();
    test_early_release();
    test_load_wrap();
    test_collision();
    test_veto();
    test_reset_mid_shift();
    test_veto_saturate();
`ifdef TLU_EMULATOR_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
